// File: rtl/pc_fetch.sv
// pc_fetch: program counter and fetch sequencing for the single-cycle MIPS datapath.
//
// Each cycle it drives the byte address of the instruction to fetch. The next
// address is chosen from sequential, beq (branch_taken/branch_imm) and j
// (jump/jump_target) inputs. A small IDLE/RUN/HALT machine handles start,
// stall and halt.
//
// Parameters:
//   ADDR_LEN   address width (32); the jump concatenation assumes 32
//   LAST_ADDR  highest legal fetch address (last word of the 256-entry store)
//
// Ports:
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   start         one-cycle pulse, leaves IDLE
//   stall         hold the PC this cycle
//   branch_taken  beq condition true; branch_imm is the raw I-type immediate
//   jump          current instruction is j; jump_target is the raw J-type field
//   inst_addr     fetch address (PC register output)
//   pc_plus4      inst_addr + 4, combinational
//   running       state == RUN
//   halted        state == HALT
//   retired       retired-instruction count
//
// Optional feature: define PC_FETCH_RETIRE_CNT_EN to build the retired counter;
// without it, retired is tied to zero and no counter register exists.

module pc_fetch #(
  parameter int                  ADDR_LEN  = 32,
  parameter logic [ADDR_LEN-1:0] LAST_ADDR = 32'h0000_03FC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [15:0]         branch_imm,
  input  logic                jump,
  input  logic [25:0]         jump_target,
  output logic [ADDR_LEN-1:0] inst_addr,
  output logic [ADDR_LEN-1:0] pc_plus4,
  output logic                running,
  output logic                halted,
  output logic [31:0]         retired
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  state_t              state;
  logic [ADDR_LEN-1:0] pc;
  logic [ADDR_LEN-1:0] branch_off;
  logic [ADDR_LEN-1:0] branch_addr;
  logic [ADDR_LEN-1:0] jump_addr;
  logic [ADDR_LEN-1:0] next_pc;
  logic                halt_now;
  logic                advance;

  assign inst_addr = pc;
  assign pc_plus4  = pc + ADDR_LEN'(4);

  // The immediate is a word offset: sign-extend it and scale it by 4.
  assign branch_off  = {{(ADDR_LEN-18){branch_imm[15]}}, branch_imm, 2'b00};
  assign branch_addr = pc_plus4 + branch_off;
  assign jump_addr   = {pc_plus4[ADDR_LEN-1:ADDR_LEN-4], jump_target, 2'b00};

  // An instruction retires on every unstalled RUN cycle, including the halting one.
  assign advance = (state == RUN) && !stall;

  // Choose the candidate next PC (jump beats branch) and flag a halt. A halt
  // fires when the candidate leaves the instruction store, or when a j targets
  // its own address, which is the program's idle loop.
  always_comb begin
    next_pc  = pc_plus4;
    halt_now = 1'b0;
    if (jump) begin
      next_pc = jump_addr;
    end else if (branch_taken) begin
      next_pc = branch_addr;
    end
    if ((next_pc > LAST_ADDR) || (jump && (jump_addr == pc))) begin
      halt_now = 1'b1;
    end
  end

  // Run-control FSM and PC register. running and halted are registered next to
  // the state, so they change on the same edge as the state. On a halt the PC
  // keeps the current address instead of loading the offending target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= '0;
      running <= 1'b0;
      halted  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (!stall) begin
            if (halt_now) begin
              state   <= HALT;
              running <= 1'b0;
              halted  <= 1'b1;
            end else begin
              pc <= next_pc;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_FETCH_RETIRE_CNT_EN
  logic [31:0] retire_cnt;

  // Retired-instruction counter. It wraps naturally at 2^32 and holds outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
    end else if (advance) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

  assign retired = retire_cnt;
`else
  assign retired = 32'd0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: self-checking bench for pc_fetch.
//
// It runs a directed vector table, a few multi-cycle sequences (asynchronous
// reset while halted, a sequential run to the end of the store) and a random
// phase that is checked against a behavioural model.

module tb_pc_fetch;

  localparam logic [31:0] LAST = 32'h0000_03FC;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic        jump;
  logic [25:0] jump_target;
  logic [31:0] inst_addr;
  logic [31:0] pc_plus4;
  logic        running;
  logic        halted;
  logic [31:0] retired;

  int total = 0;
  int bad   = 0;

  // Reference model state: 0 = idle, 1 = run, 2 = halt.
  int          m_state;
  logic [31:0] m_pc;
  logic [31:0] m_ret;

  typedef struct {
    logic        start;
    logic        stall;
    logic        br;
    logic [15:0] imm;
    logic        jmp;
    logic [25:0] tgt;
    logic [31:0] exp_addr;
    logic        exp_run;
    logic        exp_halt;
    logic [31:0] exp_ret;
  } vec_t;

  vec_t vecs[19];

  pc_fetch #(.ADDR_LEN(32), .LAST_ADDR(LAST)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jump_target  (jump_target),
    .inst_addr    (inst_addr),
    .pc_plus4     (pc_plus4),
    .running      (running),
    .halted       (halted),
    .retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Without the counter build, retired is always zero.
  function automatic logic [31:0] ret_exp(input logic [31:0] n);
`ifdef PC_FETCH_RETIRE_CNT_EN
    return n;
`else
    return n & 32'h0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] e_addr, input logic e_run,
                             input logic e_halt, input logic [31:0] e_ret);
    check({name, ".inst_addr"}, inst_addr, e_addr);
    check({name, ".pc_plus4"}, pc_plus4, e_addr + 32'd4);
    check({name, ".running"}, {31'd0, running}, {31'd0, e_run});
    check({name, ".halted"}, {31'd0, halted}, {31'd0, e_halt});
    check({name, ".retired"}, retired, ret_exp(e_ret));
  endtask

  // Drive the inputs just after an edge, then advance one edge and settle.
  task automatic applyStimulus(input logic s, input logic st, input logic br, input logic [15:0] imm,
                               input logic j, input logic [25:0] t);
    start        = s;
    stall        = st;
    branch_taken = br;
    branch_imm   = imm;
    jump         = j;
    jump_target  = t;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model of one clock edge, written from the rules with plain arithmetic.
  task automatic model_edge(input logic s, input logic st, input logic br, input logic [15:0] imm,
                            input logic j, input logic [25:0] t);
    longint nxt;
    longint off;
    if (m_state == 0) begin
      if (s) m_state = 1;
    end else if (m_state == 1 && !st) begin
      if (j) begin
        nxt = ((longint'(m_pc) + 4) / 268435456) * 268435456 + longint'(t) * 4;
      end else if (br) begin
        off = longint'(imm);
        if (off > 32767) off = off - 65536;
        nxt = (longint'(m_pc) + 4 + off * 4) % 64'sd4294967296;
        if (nxt < 0) nxt = nxt + 64'sd4294967296;
      end else begin
        nxt = longint'(m_pc) + 4;
      end
      m_ret = m_ret + 32'd1;
      if (nxt > longint'(LAST) || (j && nxt == longint'(m_pc))) m_state = 2;
      else m_pc = nxt[31:0];
    end
  endtask

  task automatic do_reset();
    start = 0; stall = 0; branch_taken = 0; branch_imm = 0; jump = 0; jump_target = 0;
    #2 rst_n = 1'b0;
    #7 rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_state = 0;
    m_pc    = 32'd0;
    m_ret   = 32'd0;
  endtask

  initial begin
    // Directed table: {start, stall, br, imm, jmp, tgt, addr, run, halt, retired}
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 26'h5,  32'h00, 1'b0, 1'b0, 32'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h0,  32'h00, 1'b1, 1'b0, 32'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h0,  32'h04, 1'b1, 1'b0, 32'd1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h0,  32'h08, 1'b1, 1'b0, 32'd2};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h0,  32'h0C, 1'b1, 1'b0, 32'd3};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 16'h0004, 1'b0, 26'h0,  32'h0C, 1'b1, 1'b0, 32'd3};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 26'h9,  32'h0C, 1'b1, 1'b0, 32'd3};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h0,  32'h10, 1'b1, 1'b0, 32'd4};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h0,  32'h14, 1'b1, 1'b0, 32'd5};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'h0004, 1'b0, 26'h0,  32'h28, 1'b1, 1'b0, 32'd6};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 16'hFFFA, 1'b0, 26'h0,  32'h14, 1'b1, 1'b0, 32'd7};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 16'hFFFB, 1'b0, 26'h0,  32'h04, 1'b1, 1'b0, 32'd8};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 26'h9,  32'h24, 1'b1, 1'b0, 32'd9};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 16'h0100, 1'b1, 26'hB,  32'h2C, 1'b1, 1'b0, 32'd10};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h0,  32'h30, 1'b1, 1'b0, 32'd11};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 26'h8,  32'h20, 1'b1, 1'b0, 32'd12};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 26'h8,  32'h20, 1'b0, 1'b1, 32'd13};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 26'h0,  32'h20, 1'b0, 1'b1, 32'd13};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 16'h0004, 1'b1, 26'h10, 32'h20, 1'b0, 1'b1, 32'd13};

    rst_n = 1'b1;
    start = 0; stall = 0; branch_taken = 0; branch_imm = 0; jump = 0; jump_target = 0;
    #1 rst_n = 1'b0;
    #3;
    checkOutput("reset", 32'h0, 1'b0, 1'b0, 32'd0);
    do_reset();
    checkOutput("reset_idle", 32'h0, 1'b0, 1'b0, 32'd0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].start, vecs[i].stall, vecs[i].br, vecs[i].imm, vecs[i].jmp, vecs[i].tgt);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_run, vecs[i].exp_halt,
                  vecs[i].exp_ret);
    end

    // Asynchronous reset in the middle of a cycle, while halted.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 32'h0, 1'b0, 1'b0, 32'd0);
    #3 rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
    checkOutput("after_reset_idle", 32'h0, 1'b0, 1'b0, 32'd0);

    // Sequential run through the whole store; the edge after 0x3FC halts.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
    checkOutput("seq_start", 32'h0, 1'b1, 1'b0, 32'd0);
    for (int k = 1; k <= 255; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
      checkOutput($sformatf("seq%0d", k), 32'(k * 4), 1'b1, 1'b0, 32'(k));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
    checkOutput("seq_halt", 32'h3FC, 1'b0, 1'b1, 32'd256);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
    checkOutput("seq_halt_hold", 32'h3FC, 1'b0, 1'b1, 32'd256);

    // Random phase against the behavioural model.
    do_reset();
    begin
      int halt_cycles;
      halt_cycles = 0;
      for (int n = 0; n < 1500; n++) begin
        logic        s, st, br, j;
        logic [15:0] imm;
        logic [25:0] t;
        s   = ($urandom % 6) == 0;
        st  = ($urandom % 4) == 0;
        br  = ($urandom % 3) == 0;
        imm = ($urandom % 8 == 0) ? 16'($urandom) : 16'($urandom_range(0, 80)) - 16'd40;
        j   = ($urandom % 7) == 0;
        t   = 26'($urandom_range(0, 270));
        applyStimulus(s, st, br, imm, j, t);
        model_edge(s, st, br, imm, j, t);
        checkOutput($sformatf("rand%0d", n), m_pc, m_state == 1, m_state == 2, m_ret);
        if (m_state == 2) halt_cycles++;
        if (halt_cycles > 3) begin
          halt_cycles = 0;
          do_reset();
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
